multicycle_control_unit: RTL

- State-machine controller for the multicycle CPU datapath.
- Sequences each instruction through IF/ID/EXE/MEM/WB.
- Generates all datapath strobes: the register-file write enable (RegWre) and its write-address/data selects, plus PC, IR, ALU and data-memory controls.
- Inputs are the current IR opcode and ALU flags. Outputs drive the existing datapath muxes and the register file directly.

---
 rtl/multicycle_control_unit_if.sv | 44 ++++
 rtl/multicycle_control_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit_if
// Controller <-> datapath bundle: IR opcode and ALU flags in, datapath strobes out.
// Revision: 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

interface multicycle_control_unit_if #(
  parameter int OP_W = 6,
  parameter int ST_W = 3
);
  logic [OP_W-1:0] OpCode;
  logic            Zero;
  logic            Sign;
  logic            PCWre;
  logic            InsMemRW;
  logic            IRWre;
  logic            RegWre;
  logic [1:0]      RegDst;
  logic            WrRegDSrc;
  logic            ALUSrcA;
  logic            ALUSrcB;
  logic            ExtSel;
  logic            DBDataSrc;
  logic [2:0]      ALUOp;
  logic [1:0]      PCSrc;
  logic            mRD;
  logic            mWR;
  logic [ST_W-1:0] State;

  modport master (
    input  OpCode, Zero, Sign,
    output PCWre, InsMemRW, IRWre, RegWre, RegDst, WrRegDSrc, ALUSrcA, ALUSrcB,
           ExtSel, DBDataSrc, ALUOp, PCSrc, mRD, mWR, State
  );

  modport slave (
    output OpCode, Zero, Sign,
    input  PCWre, InsMemRW, IRWre, RegWre, RegDst, WrRegDSrc, ALUSrcA, ALUSrcB,
           ExtSel, DBDataSrc, ALUOp, PCSrc, mRD, mWR, State
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
// IF/ID/EXE/MEM/WB sequencer generating all strobes for the multicycle datapath.
// Revision: 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module multicycle_control_unit #(
  parameter int OP_W = 6,
  parameter int ST_W = 3
) (
  input  wire logic                      CLK,
  input  wire logic                      Reset,
  multicycle_control_unit_if.master      bus
);

  typedef enum logic [ST_W-1:0] {
    S_IF   = ST_W'(3'b000),
    S_ID   = ST_W'(3'b001),
    S_EXE  = ST_W'(3'b010),
    S_MEM  = ST_W'(3'b011),
    S_WB   = ST_W'(3'b100),
    S_HALT = ST_W'(3'b111)
  } state_t;

  localparam logic [OP_W-1:0] c_OP_ADD   = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] c_OP_SUB   = OP_W'(6'b000001);
  localparam logic [OP_W-1:0] c_OP_ADDIU = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] c_OP_ANDI  = OP_W'(6'b010000);
  localparam logic [OP_W-1:0] c_OP_AND   = OP_W'(6'b010001);
  localparam logic [OP_W-1:0] c_OP_ORI   = OP_W'(6'b010010);
  localparam logic [OP_W-1:0] c_OP_OR    = OP_W'(6'b010011);
  localparam logic [OP_W-1:0] c_OP_SLL   = OP_W'(6'b011000);
  localparam logic [OP_W-1:0] c_OP_SLTI  = OP_W'(6'b100110);
  localparam logic [OP_W-1:0] c_OP_SLT   = OP_W'(6'b100111);
  localparam logic [OP_W-1:0] c_OP_SW    = OP_W'(6'b110000);
  localparam logic [OP_W-1:0] c_OP_LW    = OP_W'(6'b110001);
  localparam logic [OP_W-1:0] c_OP_BEQ   = OP_W'(6'b110100);
  localparam logic [OP_W-1:0] c_OP_BNE   = OP_W'(6'b110101);
  localparam logic [OP_W-1:0] c_OP_BLTZ  = OP_W'(6'b110110);
  localparam logic [OP_W-1:0] c_OP_J     = OP_W'(6'b111000);
  localparam logic [OP_W-1:0] c_OP_JR    = OP_W'(6'b111001);
  localparam logic [OP_W-1:0] c_OP_JAL   = OP_W'(6'b111010);
  localparam logic [OP_W-1:0] c_OP_HALT  = OP_W'(6'b111111);

  state_t     r_state;
  state_t     w_next;
  logic       w_rtype, w_itype, w_lw, w_sw, w_beq, w_bne, w_bltz;
  logic       w_j, w_jr, w_jal, w_halt, w_sll, w_zext;
  logic       w_branch, w_jump, w_nop, w_taken, w_dec_on;
  logic [2:0] w_aluop;
  logic       w_pcwre, w_insmem, w_irwre, w_regwre, w_mrd, w_mwr;

  always_comb begin : p_decode
    w_rtype = 1'b0; w_itype = 1'b0; w_lw = 1'b0; w_sw = 1'b0;
    w_beq = 1'b0; w_bne = 1'b0; w_bltz = 1'b0;
    w_j = 1'b0; w_jr = 1'b0; w_jal = 1'b0; w_halt = 1'b0;
    w_sll = 1'b0; w_zext = 1'b0; w_aluop = 3'b000;
    case (bus.OpCode)
      c_OP_ADD:   w_rtype = 1'b1;
      c_OP_SUB:   begin w_rtype = 1'b1; w_aluop = 3'b001; end
      c_OP_ADDIU: w_itype = 1'b1;
      c_OP_ANDI:  begin w_itype = 1'b1; w_zext = 1'b1; w_aluop = 3'b100; end
      c_OP_AND:   begin w_rtype = 1'b1; w_aluop = 3'b100; end
      c_OP_ORI:   begin w_itype = 1'b1; w_zext = 1'b1; w_aluop = 3'b011; end
      c_OP_OR:    begin w_rtype = 1'b1; w_aluop = 3'b011; end
      c_OP_SLL:   begin w_rtype = 1'b1; w_sll = 1'b1; w_aluop = 3'b010; end
      c_OP_SLTI:  begin w_itype = 1'b1; w_aluop = 3'b110; end
      c_OP_SLT:   begin w_rtype = 1'b1; w_aluop = 3'b110; end
      c_OP_SW:    w_sw = 1'b1;
      c_OP_LW:    w_lw = 1'b1;
      c_OP_BEQ:   begin w_beq = 1'b1; w_aluop = 3'b001; end
      c_OP_BNE:   begin w_bne = 1'b1; w_aluop = 3'b001; end
      c_OP_BLTZ:  begin w_bltz = 1'b1; w_aluop = 3'b001; end
      c_OP_J:     w_j = 1'b1;
      c_OP_JR:    w_jr = 1'b1;
      c_OP_JAL:   w_jal = 1'b1;
      c_OP_HALT:  w_halt = 1'b1;
      default:    ;
    endcase
  end

  assign w_branch = w_beq | w_bne | w_bltz;
  assign w_jump   = w_j | w_jr | w_jal;
  assign w_nop    = ~(w_rtype | w_itype | w_lw | w_sw | w_branch | w_jump | w_halt);
  assign w_taken  = (w_beq & bus.Zero) | (w_bne & ~bus.Zero) | (w_bltz & bus.Sign);

  always_ff @(posedge CLK) begin
    if (!Reset) r_state <= S_IF;
    else        r_state <= w_next;
  end

  always_comb begin : p_next_out
    w_next   = S_IF;
    w_dec_on = 1'b0;
    w_pcwre  = 1'b0; w_insmem = 1'b0; w_irwre = 1'b0;
    w_regwre = 1'b0; w_mrd    = 1'b0; w_mwr   = 1'b0;
    case (r_state)
      S_IF: begin
        w_next = S_ID; w_insmem = 1'b1; w_irwre = 1'b1;
      end
      S_ID: begin
        w_dec_on = 1'b1;
        if (w_jump | w_nop) begin
          w_next = S_IF; w_pcwre = 1'b1; w_regwre = w_jal;
        end else if (w_halt) begin
          w_next = S_HALT;
        end else begin
          w_next = S_EXE;
        end
      end
      S_EXE: begin
        w_dec_on = 1'b1;
        if (w_branch)         begin w_next = S_IF; w_pcwre = 1'b1; end
        else if (w_lw | w_sw) w_next = S_MEM;
        else                  w_next = S_WB;
      end
      S_MEM: begin
        w_dec_on = 1'b1;
        if (w_sw)      begin w_next = S_IF; w_pcwre = 1'b1; w_mwr = 1'b1; end
        else if (w_lw) begin w_next = S_WB; w_mrd = 1'b1; end
      end
      S_WB: begin
        w_dec_on = 1'b1; w_next = S_IF; w_pcwre = 1'b1; w_regwre = 1'b1;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IF;
    endcase
  end

  // Reset low must suppress every state-changing strobe, including an abort in WB/MEM.
  assign bus.PCWre    = w_pcwre  & Reset;
  assign bus.InsMemRW = w_insmem & Reset;
  assign bus.IRWre    = w_irwre  & Reset;
  assign bus.RegWre   = w_regwre & Reset;
  assign bus.mRD      = w_mrd    & Reset;
  assign bus.mWR      = w_mwr    & Reset;

  assign bus.ALUSrcA   = w_dec_on & w_sll;
  assign bus.ALUSrcB   = w_dec_on & (w_itype | w_lw | w_sw);
  assign bus.ExtSel    = w_dec_on & ~w_zext;
  assign bus.DBDataSrc = w_dec_on & w_lw;
  assign bus.ALUOp     = w_dec_on ? w_aluop : 3'b000;
  assign bus.WrRegDSrc = w_dec_on & ~w_jal;
  assign bus.RegDst    = !w_dec_on ? 2'b00 : w_jal ? 2'b00 : w_rtype ? 2'b10 : 2'b01;
  assign bus.PCSrc     = !w_dec_on           ? 2'b00 :
                         (w_j | w_jal)       ? 2'b11 :
                         w_jr                ? 2'b10 :
                         w_taken             ? 2'b01 : 2'b00;
  assign bus.State     = r_state;

endmodule

`default_nettype wire
